// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline boundary register (pipe_stage_reg).
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_VALID = 2'd1,
    ST_HELD  = 2'd2
  } pipe_state_e;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam int unsigned PIPE_PAYLOAD_W = 145;
  localparam logic [PIPE_PAYLOAD_W-1:0] PIPE_NOP_PAYLOAD = '0;

endpackage

// File: rtl/pipe_lane_reg.sv
// One payload lane of the pipeline boundary register: valid bit, payload and,
// when PIPE_STAGE_PARITY_EN is defined, a stored even-parity bit with a registered error flag.
module pipe_lane_reg #(
  parameter int unsigned PAYLOAD_W = 145,
  parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 bubble_i,
  input  logic                 load_i,
  input  logic                 valid_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  output logic                 valid_o,
  output logic [PAYLOAD_W-1:0] payload_o,
  output logic                 parity_err_o
);

  logic                 valid_q, valid_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;

  // Flush and bubble both drop the lane to a NOP; anything else that is not a load holds.
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (flush_i || bubble_i) begin
      valid_d   = 1'b0;
      payload_d = NOP_PAYLOAD;
    end else if (load_i) begin
      valid_d   = valid_i;
      payload_d = valid_i ? payload_i : NOP_PAYLOAD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      payload_q <= NOP_PAYLOAD;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;

`ifdef PIPE_STAGE_PARITY_EN
  logic parity_q, parity_d;
  logic parityErr_q, parityErr_d;

  // The error flag compares against the stored word one cycle late, so it is registered.
  always_comb begin
    parity_d = parity_q;
    if (flush_i || bubble_i) begin
      parity_d = ^NOP_PAYLOAD;
    end else if (load_i) begin
      parity_d = ^payload_i;
    end
    parityErr_d = flush_i ? 1'b0 : (valid_q && (parity_q != ^payload_q));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_q    <= ^NOP_PAYLOAD;
      parityErr_q <= 1'b0;
    end else begin
      parity_q    <= parity_d;
      parityErr_q <= parityErr_d;
    end
  end

  assign parity_err_o = parityErr_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline boundary register with occupancy FSM, hold counter and delay-slot flags.
// Optional per-lane parity checking is enabled by defining PIPE_STAGE_PARITY_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = PIPE_PAYLOAD_W,
  parameter int unsigned LANES     = 1,
  parameter int unsigned STALL_W   = 6,
  parameter int unsigned STAGE     = 2,
  parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = PAYLOAD_W'(PIPE_NOP_PAYLOAD),
  parameter int unsigned CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [STALL_W-1:0]         stall,
  input  logic                       flush,
  input  logic [LANES-1:0]           in_valid,
  input  logic [LANES*PAYLOAD_W-1:0] in_payload,
  input  logic                       id_is_in_delayslot,
  input  logic                       next_inst_in_delayslot_i,
  output logic [LANES-1:0]           out_valid,
  output logic [LANES*PAYLOAD_W-1:0] out_payload,
  output logic                       ex_is_in_delayslot,
  output logic                       is_in_delayslot_o,
  output logic [1:0]                 state_o,
  output logic [CNT_W-1:0]           hold_cnt_o,
  output logic [LANES-1:0]           parity_err_o
);

  generate
    if (STAGE + 2 > STALL_W) begin : gBadStage
      $error("pipe_stage_reg: STAGE must be <= STALL_W-2");
    end
  endgenerate

  pipe_state_e       state_q, state_d;
  logic [CNT_W-1:0]  holdCnt_q, holdCnt_d;
  logic              exDs_q, exDs_d;
  logic              isDs_q, isDs_d;
  logic              doFlush, doBubble, doLoad;
  logic              unusedStall;

  // Only the producer and consumer stall bits matter here.
  assign unusedStall = ^stall;
  assign doFlush  = flush;
  assign doBubble = !flush && (stall[STAGE] == STOP) && (stall[STAGE+1] == NOSTOP);
  assign doLoad   = !flush && (stall[STAGE] == NOSTOP);

  // Priority flush > bubble > load > hold; the unreachable encoding falls back to EMPTY.
  always_comb begin
    state_d = state_q;
    exDs_d  = exDs_q;
    isDs_d  = isDs_q;
    if (doFlush) begin
      state_d = ST_EMPTY;
      exDs_d  = 1'b0;
      isDs_d  = 1'b0;
    end else if (doBubble) begin
      state_d = ST_EMPTY;
      exDs_d  = 1'b0;
    end else if (doLoad) begin
      state_d = (|in_valid) ? ST_VALID : ST_EMPTY;
      exDs_d  = id_is_in_delayslot;
      isDs_d  = next_inst_in_delayslot_i;
    end else begin
      case (state_q)
        ST_VALID, ST_HELD: state_d = ST_HELD;
        default:           state_d = ST_EMPTY;
      endcase
    end
    holdCnt_d = '0;
    if (state_d == ST_HELD) begin
      holdCnt_d = (holdCnt_q == {CNT_W{1'b1}}) ? holdCnt_q : holdCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_EMPTY;
      holdCnt_q <= '0;
      exDs_q    <= 1'b0;
      isDs_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      holdCnt_q <= holdCnt_d;
      exDs_q    <= exDs_d;
      isDs_q    <= isDs_d;
    end
  end

  assign state_o            = state_q;
  assign hold_cnt_o         = holdCnt_q;
  assign ex_is_in_delayslot = exDs_q;
  assign is_in_delayslot_o  = isDs_q;

  generate
    for (genvar i = 0; i < LANES; i++) begin : gLane
      pipe_lane_reg #(
        .PAYLOAD_W  (PAYLOAD_W),
        .NOP_PAYLOAD(NOP_PAYLOAD)
      ) uLane (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (doFlush),
        .bubble_i    (doBubble),
        .load_i      (doLoad),
        .valid_i     (in_valid[i]),
        .payload_i   (in_payload[i*PAYLOAD_W +: PAYLOAD_W]),
        .valid_o     (out_valid[i]),
        .payload_o   (out_payload[i*PAYLOAD_W +: PAYLOAD_W]),
        .parity_err_o(parity_err_o[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a behavioural model queues expected outputs per edge,
// a monitor pops and compares them after each rising edge.
module tb_pipe_stage_reg;

  localparam int PW = 145;
  localparam int NL = 2;
  localparam int LW = PW * NL;

  typedef struct packed {
    logic [NL-1:0] valid;
    logic [LW-1:0] payload;
    logic          exDs;
    logic          isDs;
    logic [1:0]    state;
    logic [7:0]    hold;
    logic [NL-1:0] perr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    stall = '0;
  logic          flush = 1'b0;
  logic [NL-1:0] inValid = '0;
  logic [LW-1:0] inPayload = '0;
  logic          idDs = 1'b0;
  logic          nextDs = 1'b0;
  logic [NL-1:0] outValid;
  logic [LW-1:0] outPayload;
  logic          exDsOut;
  logic          isDsOut;
  logic [1:0]    stateOut;
  logic [7:0]    holdCnt;
  logic [NL-1:0] parityErr;

  exp_t expQ[$];
  exp_t model;
  int   assertCount = 0;
  int   failCount = 0;

  pipe_stage_reg #(
    .PAYLOAD_W(PW),
    .LANES    (NL),
    .STALL_W  (6),
    .STAGE    (2),
    .CNT_W    (8)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .in_valid                (inValid),
    .in_payload              (inPayload),
    .id_is_in_delayslot      (idDs),
    .next_inst_in_delayslot_i(nextDs),
    .out_valid               (outValid),
    .out_payload             (outPayload),
    .ex_is_in_delayslot      (exDsOut),
    .is_in_delayslot_o       (isDsOut),
    .state_o                 (stateOut),
    .hold_cnt_o              (holdCnt),
    .parity_err_o            (parityErr)
  );

  always #5 clk = ~clk;

  // Hard time limit so a broken design can never hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmpField(input string name, input logic [LW-1:0] got, input logic [LW-1:0] want);
    assertCount++;
    if (got !== want) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmpField("out_valid", LW'(outValid), LW'(e.valid));
    cmpField("out_payload", outPayload, e.payload);
    cmpField("ex_is_in_delayslot", LW'(exDsOut), LW'(e.exDs));
    cmpField("is_in_delayslot_o", LW'(isDsOut), LW'(e.isDs));
    cmpField("state_o", LW'(stateOut), LW'(e.state));
    cmpField("hold_cnt_o", LW'(holdCnt), LW'(e.hold));
    cmpField("parity_err_o", LW'(parityErr), LW'(e.perr));
  endtask

  function automatic logic [PW-1:0] randPayload();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[PW-1:0];
  endfunction

  function automatic logic [LW-1:0] randWide();
    logic [LW-1:0] w;
    for (int i = 0; i < NL; i++) w[i*PW +: PW] = randPayload();
    return w;
  endfunction

  task automatic modelReset();
    model = '0;
  endtask

  // Reference behaviour: decide the action for this edge, then derive the resulting outputs.
  task automatic predict(input logic [5:0] st, input logic fl, input logic [NL-1:0] v,
                         input logic [LW-1:0] p, input logic idd, input logic nxd);
    int nextState;
    if (fl) begin
      model.valid = '0; model.payload = '0; model.exDs = 0; model.isDs = 0; nextState = 0;
    end else if (st[2] && !st[3]) begin
      model.valid = '0; model.payload = '0; model.exDs = 0; nextState = 0;
    end else if (!st[2]) begin
      model.valid = v;
      for (int i = 0; i < NL; i++) model.payload[i*PW +: PW] = v[i] ? p[i*PW +: PW] : '0;
      model.exDs = idd; model.isDs = nxd;
      nextState = (v != 0) ? 1 : 0;
    end else begin
      nextState = (model.state == 0) ? 0 : 2;
    end
    model.state = 2'(nextState);
    if (nextState == 2) model.hold = (model.hold == 8'd255) ? 8'd255 : model.hold + 8'd1;
    else model.hold = 8'd0;
    model.perr = '0;
  endtask

  // Called at a falling edge: drive inputs for the coming rising edge and queue its result.
  task automatic applyStimulus(input logic [5:0] st, input logic fl, input logic [NL-1:0] v,
                               input logic [LW-1:0] p, input logic idd, input logic nxd);
    stall = st; flush = fl; inValid = v; inPayload = p; idDs = idd; nextDs = nxd;
    predict(st, fl, v, p, idd, nxd);
    expQ.push_back(model);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : stimulus
    logic [LW-1:0] pat;
    exp_t resetExp;
    logic [5:0] st;
    resetExp = '0;
    modelReset();

    // Asynchronous reset with live inputs, checked before any clock edge.
    inValid = 2'b11;
    pat = {2{145'h1234_5678_9abc_def0_1234_5678_9abc_def0}};
    inPayload = pat;
    #3 rst = 1'b0;
    #1 checkOutput(resetExp);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Plain load, then bubble with a pending delay slot.
    pat = randWide();
    applyStimulus(6'b000000, 0, 2'b11, pat, 1'b1, 1'b1);
    applyStimulus(6'b000100, 0, 2'b11, randWide(), 1'b0, 1'b0);
    applyStimulus(6'b000000, 0, 2'b01, randWide(), 1'b0, 1'b0);

    // Long hold: outputs frozen, counter saturates.
    applyStimulus(6'b000000, 0, 2'b10, randWide(), 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) applyStimulus(6'b001100, 0, 2'b11, randWide(), 1'b0, 1'b1);

    // Flush beats a simultaneous load.
    applyStimulus(6'b000000, 1, 2'b11, randWide(), 1'b1, 1'b1);

    // Load with no valid lanes, then hold: stays EMPTY.
    applyStimulus(6'b000000, 0, 2'b00, randWide(), 1'b0, 1'b0);
    applyStimulus(6'b001100, 0, 2'b11, randWide(), 1'b0, 1'b0);

    // Reset asserted in the middle of a hold.
    applyStimulus(6'b000000, 0, 2'b11, randWide(), 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(6'b001100, 0, 2'b11, randWide(), 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 checkOutput(resetExp);
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    applyStimulus(6'b001100, 0, 2'b11, randWide(), 1'b1, 1'b1);

`ifdef PIPE_STAGE_PARITY_EN
    // Corrupt one stored bit of lane 1 and expect its parity flag a cycle later.
    begin
      logic b;
      applyStimulus(6'b000000, 0, 2'b11, randWide(), 1'b0, 1'b0);
      b = dut.gLane[1].uLane.payload_q[0];
      stall = 6'b001100;
      force dut.gLane[1].uLane.payload_q[0] = ~b;
      @(posedge clk);
      #1 cmpField("parity_err_lane1", LW'(parityErr), LW'(2'b10));
      @(negedge clk);
      release dut.gLane[1].uLane.payload_q[0];
      applyStimulus(6'b000000, 1, 2'b11, randWide(), 1'b0, 1'b0);
      applyStimulus(6'b000000, 0, 2'b00, randWide(), 1'b0, 1'b0);
    end
`endif

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0:       st = 6'b000000;
        1:       st = 6'b000100;
        2:       st = 6'b001100;
        default: st = 6'($urandom);
      endcase
      applyStimulus(st, ($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)), randWide(),
                    1'($urandom), 1'($urandom));
    end

    @(posedge clk);
    #3 cmpField("scoreboard_drained", LW'(expQ.size()), LW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
